// File: rtl/static_alu_issue_ctrl.sv
// static_alu_issue_ctrl: issues float ops to an external fixed-latency ALU,
// tracks in-flight ops in a latency-indexed shift register and buffers
// results in a first-word-fall-through response FIFO.
// Optional feature macro: STATIC_ALU_INORDER_EN (responses in issue order).
module static_alu_issue_ctrl #(
    parameter int unsigned ADDER_STAGES = 2,
    parameter int unsigned MULT_STAGES  = 3,
    parameter int unsigned TAG_W        = 4,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [1:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      alu_operand_a,
    output logic [31:0]      alu_operand_b,
    output logic [1:0]       alu_operation,
    input  logic [31:0]      alu_result,
    input  logic             alu_exception,
    input  logic             alu_overflow,
    input  logic             alu_underflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [2:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag
);

    localparam int unsigned MAX_L  = (ADDER_STAGES > MULT_STAGES) ? ADDER_STAGES : MULT_STAGES;
    localparam int unsigned LAT_W  = $clog2(MAX_L + 1);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CRED_W = $clog2(MAX_L + FIFO_DEPTH + 1);

    typedef struct packed {
        logic [31:0]      result;
        logic [2:0]       flags;
        logic [TAG_W-1:0] tag;
    } rsp_entry_t;

    logic [MAX_L-1:0]       trk_valid;
    logic [MAX_L-1:0]       trk_valid_nxt;
    logic [MAX_L*TAG_W-1:0] trk_tags;
    logic [MAX_L*TAG_W-1:0] trk_tags_nxt;

    logic [LAT_W-1:0]  lat_c;
    logic              slot_busy_c;
    logic [CRED_W-1:0] inflight_c;
    logic              credit_ok_c;
    logic              fire_c;

    rsp_entry_t        mem [FIFO_DEPTH];
    rsp_entry_t        push_entry_c;
    rsp_entry_t        head_c;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FCNT_W-1:0] fifo_count;
    logic              push_c;
    logic              pop_c;

    // Latency of the requested op: add/sub use the adder, mul/reserved the multiplier
    always_comb begin
        lat_c = req_op[1] ? LAT_W'(MULT_STAGES) : LAT_W'(ADDER_STAGES);
    end

    // Writeback slot check; in-order build also blocks on any older op finishing later
    always_comb begin
        slot_busy_c = 1'b0;
        for (int i = 0; i < MAX_L; i++) begin
`ifdef STATIC_ALU_INORDER_EN
            if (trk_valid[i] && (LAT_W'(i) >= lat_c)) slot_busy_c = 1'b1;
`else
            if (trk_valid[i] && (LAT_W'(i) == lat_c)) slot_busy_c = 1'b1;
`endif
        end
    end

    // Credit: every in-flight op must have a FIFO entry reserved for it
    always_comb begin
        inflight_c = '0;
        for (int i = 0; i < MAX_L; i++) begin
            inflight_c = inflight_c + CRED_W'(trk_valid[i]);
        end
        credit_ok_c = (inflight_c + CRED_W'(fifo_count)) < CRED_W'(FIFO_DEPTH);
    end

    // Issue handshake and ALU operand drive, zero when not firing
    always_comb begin
        req_ready     = reset && !slot_busy_c && credit_ok_c;
        fire_c        = req_valid && req_ready;
        alu_operand_a = fire_c ? req_a  : 32'h0;
        alu_operand_b = fire_c ? req_b  : 32'h0;
        alu_operation = fire_c ? req_op : 2'b00;
    end

    // Tracker next state: shift toward slot 0, a fire lands in slot L-1
    always_comb begin
        trk_valid_nxt = trk_valid >> 1;
        trk_tags_nxt  = trk_tags >> TAG_W;
        if (fire_c) begin
            for (int i = 0; i < MAX_L; i++) begin
                if (LAT_W'(i + 1) == lat_c) begin
                    trk_valid_nxt[i]                = 1'b1;
                    trk_tags_nxt[i*TAG_W +: TAG_W] = req_tag;
                end
            end
        end
    end

    // Tracker state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trk_valid <= '0;
            trk_tags  <= '0;
        end else begin
            trk_valid <= trk_valid_nxt;
            trk_tags  <= trk_tags_nxt;
        end
    end

    // Capture the ALU result when the op in slot 0 completes
    always_comb begin
        push_c              = trk_valid[0];
        push_entry_c.result = alu_result;
        push_entry_c.flags  = {alu_exception, alu_overflow, alu_underflow};
        push_entry_c.tag    = trk_tags[TAG_W-1:0];
        rsp_valid           = (fifo_count != '0);
        pop_c               = rsp_valid && rsp_ready;
    end

    // FIFO storage; credit accounting guarantees there is always room
    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr] <= push_entry_c;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
                2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // First-word-fall-through head, forced to zero while empty
    always_comb begin
        head_c     = mem[rd_ptr];
        rsp_result = rsp_valid ? head_c.result : 32'h0;
        rsp_flags  = rsp_valid ? head_c.flags  : 3'b000;
        rsp_tag    = rsp_valid ? head_c.tag    : '0;
    end

endmodule

// File: tb/tb_static_alu_issue_ctrl.sv
// Directed bench for static_alu_issue_ctrl: dut0 uses A=2/M=3, dut1 uses A=1/M=3.
// A small ALU model returns a per-request result exactly L cycles after issue.
module tb_static_alu_issue_ctrl;

    localparam int unsigned TAG_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             rsp_ready;
    logic [31:0]      req_a, req_b;
    logic [1:0]       req_op;
    logic [TAG_W-1:0] req_tag;
    logic             req_valid0, req_valid1;

    logic             req_ready0, req_ready1;
    logic [31:0]      alu_operand_a0, alu_operand_b0, alu_operand_a1, alu_operand_b1;
    logic [1:0]       alu_operation0, alu_operation1;
    logic [31:0]      alu_result0, alu_result1;
    logic             exc0, ovf0, unf0, exc1, ovf1, unf1;
    logic             rsp_valid0, rsp_valid1;
    logic [31:0]      rsp_result0, rsp_result1;
    logic [2:0]       rsp_flags0, rsp_flags1;
    logic [TAG_W-1:0] rsp_tag0, rsp_tag1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // ALU model schedule: entry idx is valid when sat[idx] equals the current cycle
    int          sat0 [64];
    int          sat1 [64];
    logic [31:0] sres0 [64];
    logic [31:0] sres1 [64];
    logic [2:0]  sflg0 [64];
    logic [2:0]  sflg1 [64];

    // Response log written only by the monitor
    logic [31:0]      log0_res [64];
    logic [2:0]       log0_flg [64];
    logic [TAG_W-1:0] log0_tag [64];
    int               log0_cyc [64];
    logic [TAG_W-1:0] log1_tag [64];
    int n0 = 0;
    int n1 = 0;

    assign alu_result0 = (sat0[cyc & 63] == cyc) ? sres0[cyc & 63] : 32'hDEAD_BEEF;
    assign {exc0, ovf0, unf0} = (sat0[cyc & 63] == cyc) ? sflg0[cyc & 63] : 3'b111;
    assign alu_result1 = (sat1[cyc & 63] == cyc) ? sres1[cyc & 63] : 32'hDEAD_BEEF;
    assign {exc1, ovf1, unf1} = (sat1[cyc & 63] == cyc) ? sflg1[cyc & 63] : 3'b111;

    static_alu_issue_ctrl #(.ADDER_STAGES(2), .MULT_STAGES(3), .TAG_W(TAG_W), .FIFO_DEPTH(8)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .alu_operand_a(alu_operand_a0), .alu_operand_b(alu_operand_b0), .alu_operation(alu_operation0),
        .alu_result(alu_result0), .alu_exception(exc0), .alu_overflow(ovf0), .alu_underflow(unf0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_result(rsp_result0),
        .rsp_flags(rsp_flags0), .rsp_tag(rsp_tag0));

    static_alu_issue_ctrl #(.ADDER_STAGES(1), .MULT_STAGES(3), .TAG_W(TAG_W), .FIFO_DEPTH(8)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .alu_operand_a(alu_operand_a1), .alu_operand_b(alu_operand_b1), .alu_operation(alu_operation1),
        .alu_result(alu_result1), .alu_exception(exc1), .alu_overflow(ovf1), .alu_underflow(unf1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_result(rsp_result1),
        .rsp_flags(rsp_flags1), .rsp_tag(rsp_tag1));

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: log each popped response with its pop cycle
    always @(posedge clk) begin
        if (reset && rsp_valid0 && rsp_ready && n0 < 64) begin
            log0_res[n0] = rsp_result0;
            log0_flg[n0] = rsp_flags0;
            log0_tag[n0] = rsp_tag0;
            log0_cyc[n0] = cyc;
            n0 = n0 + 1;
        end
        if (reset && rsp_valid1 && rsp_ready && n1 < 64) begin
            log1_tag[n1] = rsp_tag1;
            n1 = n1 + 1;
        end
    end

    // One request cycle on dut d; schedules the ALU model result if it fires
    task automatic drive(input int d, input logic [1:0] op, input logic [TAG_W-1:0] tag,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [2:0] flg, output logic fired);
        int lat;
        int idx;
        @(negedge clk);
        req_a = a; req_b = b; req_op = op; req_tag = tag;
        req_valid0 = (d == 0);
        req_valid1 = (d == 1);
        #1;
        fired = (d == 0) ? req_ready0 : req_ready1;
        if (fired) begin
            lat = op[1] ? 3 : ((d == 0) ? 2 : 1);
            idx = (cyc + lat) & 63;
            if (d == 0) begin sat0[idx] = cyc + lat; sres0[idx] = res; sflg0[idx] = flg; end
            else        begin sat1[idx] = cyc + lat; sres1[idx] = res; sflg1[idx] = flg; end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_valid0 = 1'b0;
            req_valid1 = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; rsp_ready = 1'b1;
        req_valid0 = 1'b1; req_a = 32'h1234_5678; req_b = 32'h9abc_def0; req_op = 2'b10; req_tag = 4'h7;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (req_ready0 !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", req_ready0); end
        checks++; if (alu_operand_a0 !== 32'h0) begin errors++; $display("FAIL rst_alu_a: got %h want 0", alu_operand_a0); end
        checks++; if (alu_operation0 !== 2'b00) begin errors++; $display("FAIL rst_alu_op: got %b want 00", alu_operation0); end
        checks++; if (rsp_valid0 !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid0); end
        checks++; if ({rsp_result0, rsp_flags0, rsp_tag0} !== '0) begin
            errors++; $display("FAIL rst_rsp_data: got %h/%b/%h want 0", rsp_result0, rsp_flags0, rsp_tag0); end
        @(negedge clk);
        req_valid0 = 1'b0;
        reset = 1'b1;
        idle(2);
    endtask

    task automatic test_add_latency();
        logic f;
        int base, k;
        base = n0;
        drive(0, 2'b00, 4'd1, 32'h3f80_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, f);
        k = cyc;
        checks++; if (f !== 1'b1) begin errors++; $display("FAIL add_fire: got %b want 1", f); end
        checks++; if ({alu_operand_a0, alu_operand_b0, alu_operation0} !== {32'h3f80_0000, 32'h4000_0000, 2'b00}) begin
            errors++; $display("FAIL add_alu_out: got %h %h %b", alu_operand_a0, alu_operand_b0, alu_operation0); end
        idle(1);
        checks++; if (alu_operand_a0 !== 32'h0) begin errors++; $display("FAIL idle_alu_a: got %h want 0", alu_operand_a0); end
        idle(4);
        checks++; if (n0 !== base + 1) begin errors++; $display("FAIL add_rsp_count: got %0d want %0d", n0 - base, 1); end
        else begin
            checks++; if ({log0_res[base], log0_flg[base], log0_tag[base]} !== {32'h4040_0000, 3'b000, 4'd1}) begin
                errors++; $display("FAIL add_rsp: got %h/%b/%h want 40400000/000/1", log0_res[base], log0_flg[base], log0_tag[base]); end
            checks++; if (log0_cyc[base] !== k + 3) begin
                errors++; $display("FAIL add_latency: pop cycle %0d want %0d", log0_cyc[base], k + 3); end
        end
    endtask

    task automatic test_collision();
        logic f;
        int base, k;
        base = n0;
        drive(0, 2'b10, 4'd2, 32'h4000_0000, 32'h4080_0000, 32'h4100_0000, 3'b110, f);
        k = cyc;
        checks++; if (f !== 1'b1) begin errors++; $display("FAIL col_mul_fire: got %b want 1", f); end
        drive(0, 2'b00, 4'd3, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 3'b001, f);
        checks++; if (f !== 1'b0) begin errors++; $display("FAIL col_add_blocked: got %b want 0", f); end
        drive(0, 2'b00, 4'd3, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 3'b001, f);
        checks++; if (f !== 1'b1 || cyc !== k + 2) begin
            errors++; $display("FAIL col_add_retry: fired %b at %0d want 1 at %0d", f, cyc, k + 2); end
        idle(6);
        checks++; if (n0 !== base + 2) begin errors++; $display("FAIL col_count: got %0d want 2", n0 - base); end
        else begin
            checks++; if ({log0_tag[base], log0_tag[base + 1]} !== {4'd2, 4'd3}) begin
                errors++; $display("FAIL col_order: got %h,%h want 2,3", log0_tag[base], log0_tag[base + 1]); end
            checks++; if ({log0_res[base], log0_flg[base], log0_res[base + 1], log0_flg[base + 1]} !==
                          {32'h4100_0000, 3'b110, 32'h4080_0000, 3'b001}) begin
                errors++; $display("FAIL col_data: got %h/%b %h/%b", log0_res[base], log0_flg[base], log0_res[base + 1], log0_flg[base + 1]); end
        end
    endtask

    task automatic test_reserved_op();
        logic f;
        int base, k;
        base = n0;
        drive(0, 2'b11, 4'd4, 32'h1, 32'h2, 32'h7fc0_0000, 3'b100, f);
        k = cyc;
        checks++; if (f !== 1'b1 || alu_operation0 !== 2'b11) begin
            errors++; $display("FAIL rsv_fire: fired %b op %b want 1 11", f, alu_operation0); end
        idle(6);
        checks++; if (n0 !== base + 1 || log0_cyc[base] !== k + 4 || log0_tag[base] !== 4'd4) begin
            errors++; $display("FAIL rsv_latency: count %0d cycle %0d tag %h want 1 %0d 4", n0 - base, log0_cyc[base], log0_tag[base], k + 4); end
    endtask

    task automatic test_back_to_back();
        logic f;
        int base, k0;
        base = n0;
        k0 = -1;
        for (int j = 0; j < 6; j++) begin
            drive(0, 2'b00, TAG_W'(j), 32'h0, 32'h0, 32'h200 + j, 3'b000, f);
            if (j == 0) k0 = cyc;
            checks++; if (f !== 1'b1) begin errors++; $display("FAIL b2b_fire%0d: got %b want 1", j, f); end
        end
        idle(5);
        checks++; if (n0 !== base + 6) begin errors++; $display("FAIL b2b_count: got %0d want 6", n0 - base); end
        else begin
            for (int j = 0; j < 6; j++) begin
                checks++; if (log0_tag[base + j] !== TAG_W'(j) || log0_res[base + j] !== 32'h200 + j || log0_cyc[base + j] !== k0 + 3 + j) begin
                    errors++; $display("FAIL b2b_rsp%0d: tag %h res %h cyc %0d want %h %h %0d", j,
                        log0_tag[base + j], log0_res[base + j], log0_cyc[base + j], j, 32'h200 + j, k0 + 3 + j); end
            end
        end
    endtask

    task automatic test_credit();
        logic f;
        int base, fires;
        base = n0;
        fires = 0;
        rsp_ready = 1'b0;
        for (int j = 0; j < 10; j++) begin
            drive(0, 2'b00, TAG_W'(j), 32'h0, 32'h0, 32'h100 + j, 3'b000, f);
            if (f) fires++;
            checks++; if (f !== (j < 8)) begin errors++; $display("FAIL credit_fire%0d: got %b want %b", j, f, j < 8); end
        end
        idle(2);
        checks++; if (fires !== 8 || rsp_valid0 !== 1'b1 || rsp_tag0 !== 4'd0) begin
            errors++; $display("FAIL credit_full: fires %0d valid %b head %h want 8 1 0", fires, rsp_valid0, rsp_tag0); end
        @(negedge clk);
        req_op = 2'b00; rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready0 !== 1'b0) begin errors++; $display("FAIL credit_same_cycle: got %b want 0", req_ready0); end
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++; if (req_ready0 !== 1'b1) begin errors++; $display("FAIL credit_return: got %b want 1", req_ready0); end
        rsp_ready = 1'b1;
        idle(10);
        checks++; if (n0 !== base + 8) begin errors++; $display("FAIL credit_drain: got %0d want 8", n0 - base); end
        else begin
            for (int j = 0; j < 8; j++) begin
                checks++; if (log0_tag[base + j] !== TAG_W'(j) || log0_res[base + j] !== 32'h100 + j) begin
                    errors++; $display("FAIL credit_rsp%0d: tag %h res %h want %h %h", j, log0_tag[base + j], log0_res[base + j], j, 32'h100 + j); end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic f;
        int base, fires;
        base = n0;
        fires = 0;
        rsp_ready = 1'b0;
        drive(0, 2'b00, 4'd8, 32'h0, 32'h0, 32'h300, 3'b000, f);
        idle(3);
        checks++; if (rsp_valid0 !== 1'b1) begin errors++; $display("FAIL mrst_pre_valid: got %b want 1", rsp_valid0); end
        for (int j = 0; j < 3; j++) begin
            drive(0, 2'b10, TAG_W'(9 + j), 32'h0, 32'h0, 32'h400 + j, 3'b000, f);
            if (f) fires++;
        end
        checks++; if (fires !== 3) begin errors++; $display("FAIL mrst_fires: got %0d want 3", fires); end
        @(negedge clk);
        req_valid0 = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if (rsp_valid0 !== 1'b0 || rsp_tag0 !== 4'd0 || rsp_result0 !== 32'h0) begin
            errors++; $display("FAIL mrst_now: valid %b tag %h res %h want 0", rsp_valid0, rsp_tag0, rsp_result0); end
        @(negedge clk);
        reset = 1'b1;
        rsp_ready = 1'b1;
        idle(8);
        checks++; if (n0 !== base || rsp_valid0 !== 1'b0) begin
            errors++; $display("FAIL mrst_after: responses %0d valid %b want 0 0", n0 - base, rsp_valid0); end
    endtask

    task automatic test_inorder();
        logic f;
        int base, k, fc;
        logic [2*TAG_W-1:0] want;
        base = n1;
        fc = -1;
        rsp_ready = 1'b1;
        drive(1, 2'b10, 4'd5, 32'h0, 32'h0, 32'hAAAA_0005, 3'b010, f);
        k = cyc;
        checks++; if (f !== 1'b1) begin errors++; $display("FAIL ord_mul_fire: got %b want 1", f); end
        for (int j = 0; j < 6; j++) begin
            drive(1, 2'b00, 4'd6, 32'h0, 32'h0, 32'hBBBB_0006, 3'b001, f);
            if (f) begin fc = cyc; break; end
        end
        idle(6);
`ifdef STATIC_ALU_INORDER_EN
        checks++; if (fc !== k + 3) begin errors++; $display("FAIL ord_add_fire: cycle %0d want %0d", fc, k + 3); end
        want = {4'd5, 4'd6};
`else
        checks++; if (fc !== k + 1) begin errors++; $display("FAIL ord_add_fire: cycle %0d want %0d", fc, k + 1); end
        want = {4'd6, 4'd5};
`endif
        checks++; if (n1 !== base + 2 || {log1_tag[base], log1_tag[base + 1]} !== want) begin
            errors++; $display("FAIL ord_order: count %0d tags %h,%h want 2 %h", n1 - base, log1_tag[base], log1_tag[base + 1], want); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin sat0[i] = -1; sat1[i] = -1; end
        req_valid0 = 1'b0; req_valid1 = 1'b0;
        req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
        test_reset();
        test_add_latency();
        test_collision();
        test_reserved_op();
        test_back_to_back();
        test_credit();
        test_mid_reset();
        test_inorder();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
